// File: rtl/lcd1602_bus_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd1602_bus_writer_if
// Purpose  : Byte handshake from the LCD1602 sequencer plus the HD44780-style
//            8-bit write bus driven by lcd1602_bus_writer.
// Revision : 1.0  initial release
// ============================================================================
interface lcd1602_bus_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       busy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  // Sequencer side: offers bytes, observes the bus.
  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
  );

  // Writer side: accepts bytes, drives the bus.
  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
  );
endinterface
`default_nettype wire

// File: rtl/lcd1602_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd1602_bus_writer
// Purpose  : Cycle-timed HD44780 write engine: power-on delay, then per byte
//            RS/DATA setup, one EN pulse, hold and controller execution wait.
// Revision : 1.0  initial release
// ============================================================================
module lcd1602_bus_writer #(
  parameter int SETUP_CYC     = 4,
  parameter int EN_HIGH_CYC   = 25,
  parameter int HOLD_CYC      = 5,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int POWERUP_CYC   = 2000000,
  parameter int CNT_W         = 22
) (
  input  wire logic           clock,
  input  wire logic           reset,
  lcd1602_bus_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_IDLE    = 3'd1,
    S_SETUP   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLD    = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  // Timer reload values: the counter runs from N-1 down to 0, so a state
  // whose reload is N-1 occupies exactly N clocks.
  localparam logic [CNT_W-1:0] C_SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_EN_LD      = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] C_EXEC_LD    = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] C_LONG_LD    = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] C_POWERUP_LD = CNT_W'(POWERUP_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_long;
  logic             r_ready;
  logic             r_busy;
  logic             r_en;
  logic             r_rs;
  logic [7:0]       r_data;

  logic w_accept;
  logic w_timer_done;
  logic w_long_cmd;

  assign w_accept     = bus.in_valid & r_ready;
  assign w_timer_done = (r_timer == '0);
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign w_long_cmd   = ~bus.in_rs & (bus.in_data[7:2] == 6'd0) & (bus.in_data != 8'd0);

  // Sequence power-up, setup, EN pulse, hold and execution wait per byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_POWERUP;
      r_timer <= C_POWERUP_LD;
      r_long  <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        S_POWERUP: begin
          if (w_timer_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= bus.in_data;
            r_rs    <= bus.in_rs;
            r_long  <= w_long_cmd;
            r_state <= S_SETUP;
            r_timer <= C_SETUP_LD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_timer_done) begin
            r_en    <= 1'b1;
            r_state <= S_PULSE;
            r_timer <= C_EN_LD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_PULSE: begin
          if (w_timer_done) begin
            r_en    <= 1'b0;
            r_state <= S_HOLD;
            r_timer <= C_HOLD_LD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_HOLD: begin
          if (w_timer_done) begin
            r_state <= S_WAIT;
            r_timer <= r_long ? C_LONG_LD : C_EXEC_LD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_WAIT: begin
          if (w_timer_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= S_POWERUP;
          r_timer <= C_POWERUP_LD;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.busy     = r_busy;
  assign bus.LCD_DATA = r_data;
  assign bus.LCD_RS   = r_rs;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_EN   = r_en;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd1602_bus_writer
// Purpose  : Directed self-checking bench for lcd1602_bus_writer with short
//            timing overrides (SETUP=2, EN=3, HOLD=2, EXEC=5, LONG=20, PWR=10).
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd1602_bus_writer;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  lcd1602_bus_writer_if bus ();

  lcd1602_bus_writer #(
    .SETUP_CYC     (2),
    .EN_HIGH_CYC   (3),
    .HOLD_CYC      (2),
    .EXEC_CYC      (5),
    .LONG_EXEC_CYC (20),
    .POWERUP_CYC   (10),
    .CNT_W         (22)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step edges (numbered from 1) until in_ready is seen high, recording EN
  // activity and any disturbance of the latched bus or of busy.
  task automatic run_until_ready(input bit scramble, output int rdy_edge, output int en_rise,
                                 output int en_fall, output int pulses, output int errs);
    logic [7:0] d0;
    logic       rs0;
    logic       prev_en;
    d0 = bus.LCD_DATA;
    rs0 = bus.LCD_RS;
    prev_en = bus.LCD_EN;
    rdy_edge = -1; en_rise = -1; en_fall = -1; pulses = 0; errs = 0;
    for (int e = 1; e <= 200; e++) begin
      if (scramble) begin
        bus.in_data = 8'($urandom);
        bus.in_rs   = 1'($urandom);
      end
      tick();
      if (bus.LCD_DATA !== d0 || bus.LCD_RS !== rs0) errs++;
      if (bus.busy !== ~bus.in_ready) errs++;
      if (bus.LCD_RW !== 1'b0) errs++;
      if (bus.LCD_EN && !prev_en) begin
        pulses++;
        if (en_rise < 0) en_rise = e;
      end
      if (!bus.LCD_EN && prev_en && en_fall < 0) en_fall = e;
      prev_en = bus.LCD_EN;
      if (bus.in_ready) begin
        rdy_edge = e;
        break;
      end
    end
  endtask

  // Offer one byte (accepted at the next edge, edge 0) and verify its timing.
  task automatic txn(input logic rs, input logic [7:0] d, input int exp_rdy, input bit valid_busy);
    int rdy, rise, fall, pulses, errs;
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_data  = d;
    tick();
    check($sformatf("acc_data_%02h", d), bus.LCD_DATA, d);
    check($sformatf("acc_rs_%02h", d), bus.LCD_RS, rs);
    check($sformatf("acc_ready_%02h", d), bus.in_ready, 1'b0);
    bus.in_valid = valid_busy;
    run_until_ready(1'b1, rdy, rise, fall, pulses, errs);
    check($sformatf("en_rise_%02h", d), rise, 2);
    check($sformatf("en_fall_%02h", d), fall, 5);
    check($sformatf("pulses_%02h", d), pulses, 1);
    check($sformatf("stable_%02h", d), errs, 0);
    check($sformatf("ready_edge_%02h", d), rdy, exp_rdy);
  endtask

  initial begin
    int rdy, rise, fall, pulses, errs;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'h00;

    // Reset held several cycles: outputs at reset values.
    tick(); tick(); tick();
    check("rst_ready", bus.in_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_en", bus.LCD_EN, 1'b0);
    check("rst_data", bus.LCD_DATA, 8'h00);
    check("rst_rs", bus.LCD_RS, 1'b0);
    check("rst_rw", bus.LCD_RW, 1'b0);

    // Power-up delay with in_valid low.
    reset = 1'b0;
    run_until_ready(1'b0, rdy, rise, fall, pulses, errs);
    check("pwr_ready_edge", rdy, 10);
    check("pwr_pulses", pulses, 0);
    check("pwr_stable", errs, 0);
    check("pwr_busy", bus.busy, 1'b0);

    // Single character write.
    txn(1'b1, 8'h48, 12, 1'b0);

    // Long-exec commands vs normal command and data.
    txn(1'b0, 8'h01, 27, 1'b0);
    txn(1'b0, 8'h02, 27, 1'b0);
    txn(1'b0, 8'h03, 27, 1'b0);
    txn(1'b0, 8'h04, 12, 1'b0);
    txn(1'b0, 8'h38, 12, 1'b0);
    txn(1'b1, 8'h01, 12, 1'b0);

    // Back-to-back stream with in_valid held high through every wait.
    txn(1'b0, 8'h80, 12, 1'b1);
    txn(1'b1, 8'h48, 12, 1'b1);
    txn(1'b1, 8'h65, 12, 1'b0);

    // Reset mid-pulse.
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("mid_en_high", bus.LCD_EN, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_en", bus.LCD_EN, 1'b0);
    check("mid_rst_data", bus.LCD_DATA, 8'h00);
    check("mid_rst_ready", bus.in_ready, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b1);

    // Power-up again with in_valid asserted throughout: nothing accepted.
    reset = 1'b0;
    bus.in_valid = 1'b1;
    run_until_ready(1'b1, rdy, rise, fall, pulses, errs);
    check("rep_ready_edge", rdy, 10);
    check("rep_pulses", pulses, 0);
    check("rep_stable", errs, 0);
    check("rep_data_zero", bus.LCD_DATA, 8'h00);

    // First accept lands on the first edge in IDLE.
    txn(1'b1, 8'h55, 12, 1'b0);

    // Idle: bus holds, no EN activity.
    bus.in_valid = 1'b0;
    run_until_ready(1'b0, rdy, rise, fall, pulses, errs);
    check("idle_ready_edge", rdy, 1);
    tick(); tick(); tick();
    check("idle_en", bus.LCD_EN, 1'b0);
    check("idle_data", bus.LCD_DATA, 8'h55);
    check("idle_rs", bus.LCD_RS, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
